tile_result_packer: RTL

TILE_RESULT_PACKER -- requirements
Module: tile_result_packer

---
 rtl/tile_result_packer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/tile_result_packer.sv
// Packs 16-bit per-pixel results into 32-bit memory words, pairing each even
// pixel with the odd pixel that follows it. A lone pixel goes out as a partial word.
module tile_result_packer #(
  parameter int unsigned FLUSH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_addr,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_flush,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        busy,
  output logic [15:0] word_count
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 16;
  localparam int unsigned TW = 8;
  localparam logic [TW-1:0] TIMEOUT = TW'(FLUSH_TIMEOUT);

  logic          hold_valid;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_data;
  logic [TW-1:0] timer;

  logic          out_free;
  logic          pair_match;
  logic          odd_mismatch;
  logic          accept;
  logic          emit;
  logic [AW-1:0] emit_addr;
  logic [31:0]   emit_wdata;
  logic [3:0]    emit_byteen;
  logic          hold_load;
  logic          hold_clear;

  // The hold register only ever contains even pixels, so +1 cannot wrap.
  assign out_free     = !mem_valid || mem_ready;
  assign pair_match   = hold_valid && (in_addr == hold_addr + 32'd1);
  assign odd_mismatch = hold_valid && in_addr[0] && !pair_match;
  assign in_ready     = out_free && !odd_mismatch;
  assign accept       = in_valid && in_ready;
  assign busy         = hold_valid || mem_valid;

  // Decide what (if anything) is emitted and how the hold register changes.
  always_comb begin
    emit        = 1'b0;
    emit_addr   = '0;
    emit_wdata  = '0;
    emit_byteen = '0;
    hold_load   = 1'b0;
    hold_clear  = 1'b0;
    if (out_free) begin
      if (accept) begin
        if (!hold_valid) begin
          if (in_addr[0]) begin
            emit        = 1'b1;
            emit_addr   = {1'b0, in_addr[AW-1:1]};
            emit_wdata  = {in_data, 16'h0000};
            emit_byteen = 4'b1100;
          end else begin
            hold_load = 1'b1;
          end
        end else if (pair_match) begin
          emit        = 1'b1;
          emit_addr   = {1'b0, hold_addr[AW-1:1]};
          emit_wdata  = {in_data, hold_data};
          emit_byteen = 4'b1111;
          hold_clear  = 1'b1;
        end else begin
          // New even pixel displaces the held one as a partial word.
          emit        = 1'b1;
          emit_addr   = {1'b0, hold_addr[AW-1:1]};
          emit_wdata  = {16'h0000, hold_data};
          emit_byteen = 4'b0011;
          hold_load   = 1'b1;
        end
      end else if (hold_valid &&
                   ((in_valid && odd_mismatch) || in_flush || timer == TIMEOUT)) begin
        emit        = 1'b1;
        emit_addr   = {1'b0, hold_addr[AW-1:1]};
        emit_wdata  = {16'h0000, hold_data};
        emit_byteen = 4'b0011;
        hold_clear  = 1'b1;
      end
    end
  end

  // Hold register and its age timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_data  <= '0;
      timer      <= '0;
    end else if (hold_load) begin
      hold_valid <= 1'b1;
      hold_addr  <= in_addr;
      hold_data  <= in_data;
      timer      <= '0;
    end else if (hold_clear) begin
      hold_valid <= 1'b0;
      timer      <= '0;
    end else if (hold_valid && timer != TIMEOUT) begin
      timer <= timer + TW'(1);
    end
  end

  // Output word register; payload is frozen while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_byteen <= '0;
    end else if (emit) begin
      mem_valid  <= 1'b1;
      mem_addr   <= emit_addr;
      mem_wdata  <= emit_wdata;
      mem_byteen <= emit_byteen;
    end else if (mem_ready) begin
      mem_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count <= '0;
    end else if (mem_valid && mem_ready) begin
      word_count <= word_count + 16'd1;
    end
  end

endmodule
